// File: rtl/rr_pop_stage.sv
// rr_pop_stage: pops the arbiter-selected FWFT FIFO into a 2-entry registered
// output buffer (valid/ready). Define RR_POP_STATS_EN for per-queue pop counters.
`ifdef RR_POP_STATS_EN
module rr_pop_stat_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (clr)                     cnt <= '0;
    else if (inc && cnt != 16'hFFFF)  cnt <= cnt + 16'd1;
  end
endmodule
`endif

module rr_pop_stage #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  localparam int SEL_W = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [SEL_W-1:0]                    selector,
  input  logic                                selector_enb,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data,
  input  logic                                out_ready,
`ifdef RR_POP_STATS_EN
  input  logic                                stat_clr,
  output logic [QUEUE_QUANTITY*16-1:0]        stat_count,
`endif
  output logic [QUEUE_QUANTITY-1:0]           pop,
  output logic                                rr_enb,
  output logic                                out_valid,
  output logic [DATA_BITS-1:0]                out_data,
  output logic [SEL_W-1:0]                    out_queue
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  typedef struct packed {
    logic [SEL_W-1:0]     queue;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  state_t state, state_nxt;
  entry_t slot0, slot1, in_ent;
  logic   push, drain, ld0, ld1, mv10;

  // push looks only at registered occupancy so pop never depends on out_ready
  assign push   = !rst && enb && selector_enb && (state != FULL);
  assign drain  = out_valid && out_ready;
  assign in_ent = {selector, fifo_data[selector*DATA_BITS +: DATA_BITS]};
  assign rr_enb = push;

  always_comb begin
    pop = '0;
    if (push) pop[selector] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    ld0       = 1'b0;
    ld1       = 1'b0;
    mv10      = 1'b0;
    case (state)
      EMPTY: if (push) begin state_nxt = ONE; ld0 = 1'b1; end
      ONE: begin
        if (push && drain) ld0 = 1'b1;
        else if (push) begin state_nxt = FULL; ld1 = 1'b1; end
        else if (drain) state_nxt = EMPTY;
      end
      FULL: if (drain) begin state_nxt = ONE; mv10 = 1'b1; end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      state <= state_nxt;
      if (ld0)       slot0 <= in_ent;
      else if (mv10) slot0 <= slot1;
      if (ld1)       slot1 <= in_ent;
    end
  end

  assign out_valid = (state != EMPTY);
  assign out_data  = slot0.data;
  assign out_queue = slot0.queue;

`ifdef RR_POP_STATS_EN
  logic [QUEUE_QUANTITY-1:0][15:0] cnt;

  for (genvar q = 0; q < QUEUE_QUANTITY; q++) begin : g_ctr
    rr_pop_stat_ctr u_ctr (
      .clk (clk),
      .rst (rst),
      .clr (stat_clr),
      .inc (pop[q]),
      .cnt (cnt[q])
    );
  end

  assign stat_count = cnt;
`endif
endmodule

// File: doc/rr_pop_stage.md
Name: rr_pop_stage

Overview:
- Downstream consumer of the round-robin arbiter.
- Takes the arbiter's selector/selector_enb, pops one word from the selected first-word-fall-through FIFO, and forwards it through a 2-entry registered output buffer with a valid/ready handshake.
- Drives the arbiter's enb so that the arbiter advances only when a word is actually popped.

Parameters:
- QUEUE_QUANTITY, 4, number of source FIFOs; must match the arbiter.
- DATA_BITS, 8, width of each FIFO word.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- enb  input  1  stage enable; no pops while low. Draining still proceeds.
- selector  input  $clog2(QUEUE_QUANTITY)  queue index from the arbiter.
- selector_enb  input  1  selector is valid (some queue is non-empty).
- fifo_data  input  QUEUE_QUANTITY*DATA_BITS  head word of each FIFO; queue i occupies bits [i*DATA_BITS +: DATA_BITS].
- out_ready  input  1  downstream accepts out_data this cycle.
- pop  output  QUEUE_QUANTITY  one-hot read strobe to the FIFOs.
- rr_enb  output  1  enb to the arbiter; equals |pop.
- out_valid  output  1  out_data/out_queue hold a word.
- out_data  output  DATA_BITS  head word of the output buffer.
- out_queue  output  $clog2(QUEUE_QUANTITY)  source queue of out_data.

Behaviour:
- Buffer is a 2-entry FIFO: slot0 is the head, slot1 is the skid entry. Each entry holds {queue, data}.
- FSM on occupancy: EMPTY(0), ONE(1), FULL(2).
- Signal definitions:
  - push = enb & selector_enb & (state != FULL). Depends only on registered state, never on out_ready.
  - drain = out_valid & out_ready.
- pop[selector] = push; all other pop bits are 0. rr_enb = push.
- On push, {selector, fifo_data[selector]} is captured at the same posedge. The FIFO advances at that same edge.
- Transitions:
  - EMPTY: push -> ONE (slot0 loaded).
  - ONE: push & !drain -> FULL (slot1 loaded). push & drain -> ONE (slot0 replaced with the new word). !push & drain -> EMPTY. Otherwise hold.
  - FULL: drain -> ONE (slot1 moves to slot0). Otherwise hold. No push occurs in FULL.
- out_valid = (state != EMPTY). out_data and out_queue come from slot0 and are registered, not combinational from the inputs.
- While out_valid is high and out_ready is low, out_data and out_queue are stable.
- Latency: push in cycle N gives out_valid in cycle N+1.
- Throughput: 1 word/cycle sustained in ONE when out_ready is continuously high.
- selector_enb low: pop = 0 and rr_enb = 0, so the arbiter does not advance.
- FULL with selector_enb high: no pop, rr_enb = 0, and the arbiter holds its pointer.
- Reset values: state EMPTY, out_valid 0, out_data 0, out_queue 0, pop 0, rr_enb 0.
- Reset asserted mid-operation:
  - Buffered words are discarded immediately.
  - out_valid falls asynchronously.
  - pop is forced to 0 while rst is high.
- Order is preserved: words leave in pop order regardless of source queue.

Optional Feature:
- Macro RR_POP_STATS_EN.
- Defined:
  - Adds output stat_count, width QUEUE_QUANTITY*16, plus input stat_clr (1 bit).
  - Counter i increments when pop[i] is asserted and saturates at 16'hFFFF.
  - stat_clr synchronously zeroes all counters; a pop in the same cycle is not counted.
  - rst clears all counters.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle with selector_enb=0 -> pop=0, rr_enb=0, out_valid=0 for 10 cycles.
- selector=2, selector_enb=1, fifo_data queue2=8'hA5, out_ready=1 -> pop=4'b0100 in cycle N; out_valid=1, out_data=8'hA5, out_queue=2 in cycle N+1; 1 word/cycle thereafter.
- Backpressure with out_ready=0 and 3 words offered (queues 0,1,3) -> two pops, then pop=0 and rr_enb=0. Raising out_ready yields 0,1 in order, then the queue 3 word is popped.
- out_ready toggling 1/0 every cycle for 20 cycles -> no word lost or duplicated; out_data stable while out_valid=1 and out_ready=0.
- rst asserted asynchronously while FULL -> out_valid=0 before the next clock edge; after release, state is EMPTY and the first pop goes to the current selector.
- RR_POP_STATS_EN: 70000 pops from queue 1 -> stat_count[31:16]=16'hFFFF; stat_clr -> all zero next cycle.
